// File: rtl/uart_transmitter.sv
// UART transmit path: start bit, 8 data bits LSB first, even parity, one stop bit.
// Bit timing is 16 oversample ticks per bit from a built-in baud divider, matching
// the receiver's baud_select table so both ends interoperate.
module uart_transmitter #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    // Divider for one oversample tick, rounded to nearest with halves up.
    function automatic int unsigned div_for(input int unsigned baud);
        return (CLK_HZ + 8 * baud) / (16 * baud);
    endfunction

    localparam int unsigned DivW = $clog2(div_for(300) + 1);

    localparam logic [DivW-1:0] Div300    = DivW'(div_for(300));
    localparam logic [DivW-1:0] Div1200   = DivW'(div_for(1200));
    localparam logic [DivW-1:0] Div4800   = DivW'(div_for(4800));
    localparam logic [DivW-1:0] Div9600   = DivW'(div_for(9600));
    localparam logic [DivW-1:0] Div19200  = DivW'(div_for(19200));
    localparam logic [DivW-1:0] Div38400  = DivW'(div_for(38400));
    localparam logic [DivW-1:0] Div57600  = DivW'(div_for(57600));
    localparam logic [DivW-1:0] Div115200 = DivW'(div_for(115200));

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic              txd_d, busy_d, done_d;
    logic [DivW-1:0]   div_sel;
    logic              accept, tick, bit_end;

    // Divider value for the requested baud code.
    always_comb begin
        div_sel = Div115200;
        case (baud_select)
            3'd0: div_sel = Div300;
            3'd1: div_sel = Div1200;
            3'd2: div_sel = Div4800;
            3'd3: div_sel = Div9600;
            3'd4: div_sel = Div19200;
            3'd5: div_sel = Div38400;
            3'd6: div_sel = Div57600;
            default: div_sel = Div115200;
        endcase
    end

    assign accept  = Tx_WR && Tx_EN && !Tx_BUSY;
    assign tick    = (div_cnt_q == div_q - DivW'(1));
    assign bit_end = tick && (tick_cnt_q == 4'd15);

    // State and datapath registers; reset drops any frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            data_q     <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            idx_q      <= '0;
            TxD        <= 1'b1;
            Tx_BUSY    <= 1'b0;
            Tx_DONE    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            idx_q      <= idx_d;
            TxD        <= txd_d;
            Tx_BUSY    <= busy_d;
            Tx_DONE    <= done_d;
        end
    end

    // Next state: counters clear on accept so bit edges are phase-locked to the write.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        idx_d      = idx_q;
        if (state_q == StIdle) begin
            if (accept) begin
                state_d    = StStart;
                data_d     = Tx_DATA;
                div_d      = div_sel;
                div_cnt_d  = '0;
                tick_cnt_d = '0;
                idx_d      = '0;
            end
        end else begin
            if (tick) begin
                div_cnt_d  = '0;
                tick_cnt_d = tick_cnt_q + 4'd1;
            end else begin
                div_cnt_d  = div_cnt_q + DivW'(1);
            end
            if (bit_end) begin
                unique case (state_q)
                    StStart:  state_d = StData;
                    StData: begin
                        if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
                        else               state_d = StParity;
                    end
                    StParity: state_d = StStop;
                    StStop:   state_d = StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    // Outputs are decoded from the next state so they land in registers.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != StIdle);
        done_d = (state_q == StStop) && (state_d == StIdle);
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = data_d[idx_d];
            StParity: txd_d = ^data_d;
            default:  txd_d = 1'b1;
        endcase
    end

endmodule
